// File: rtl/timer_bank.sv
// Multi-channel programmable down-counter bank with a shared prescaler.
// Each channel has its own mode, reload, sticky status and a registered expiry pulse.
module timer_bank #(
    parameter int WIDTH          = 16,
    parameter int CHANNELS       = 4,
    parameter int PRESCALE_WIDTH = 8,
    localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [CH_W-1:0]           wr_ch,
    input  logic [1:0]                wr_mode,
    input  logic [WIDTH-1:0]          wr_load,
    input  logic [CHANNELS-1:0]       start,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [CHANNELS-1:0]       irq_en,
    input  logic [CHANNELS-1:0]       irq_clear,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       expired,
    output logic [CHANNELS-1:0]       irq_status,
    output logic                      irq
);

    typedef enum logic [1:0] {
        MODE_FREE   = 2'b00,
        MODE_CYCLIC = 2'b01,
        MODE_SINGLE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    logic [PRESCALE_WIDTH-1:0] p_q, p_d;
    logic                      tick;

    logic [WIDTH-1:0]    count_q  [CHANNELS];
    logic [WIDTH-1:0]    count_d  [CHANNELS];
    logic [WIDTH-1:0]    reload_q [CHANNELS];
    logic [WIDTH-1:0]    reload_d [CHANNELS];
    mode_e               mode_q   [CHANNELS];
    mode_e               mode_d   [CHANNELS];
    logic [CHANNELS-1:0] halted_q, halted_d;
    logic [CHANNELS-1:0] expired_q, expired_d;
    logic [CHANNELS-1:0] status_q, status_d;

    // ">=" lets a lowered divisor take effect on the very next cycle.
    always_comb begin
        tick = (p_q >= prescale);
        p_d  = tick ? '0 : p_q + PRESCALE_WIDTH'(1);
    end

    // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned (no latch).
    always_comb begin
        count_d   = count_q;
        reload_d  = reload_q;
        mode_d    = mode_q;
        halted_d  = halted_q;
        expired_d = '0;
        status_d  = status_q & ~irq_clear;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_en && (wr_ch == CH_W'(i))) begin
                mode_d[i]   = mode_e'(wr_mode);
                reload_d[i] = wr_load;
                count_d[i]  = wr_load;
                halted_d[i] = 1'b0;
            end else if (tick && start[i] && !halted_q[i]) begin
                unique case (mode_q[i])
                    MODE_FREE: begin
                        if (count_q[i] != '0) begin
                            count_d[i] = count_q[i] - WIDTH'(1);
                        end else begin
                            count_d[i]   = '1;
                            expired_d[i] = 1'b1;
                        end
                    end
                    MODE_CYCLIC: begin
                        if (count_q[i] != '0) begin
                            count_d[i] = count_q[i] - WIDTH'(1);
                        end else begin
                            count_d[i]   = reload_q[i];
                            expired_d[i] = 1'b1;
                        end
                    end
                    MODE_SINGLE: begin
                        if (count_q[i] != '0) begin
                            count_d[i] = count_q[i] - WIDTH'(1);
                        end else begin
                            halted_d[i]  = 1'b1;
                            expired_d[i] = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            // An expiry on the same edge as a clear keeps the flag set.
            if (expired_d[i]) begin
                status_d[i] = 1'b1;
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q       <= '0;
            halted_q  <= '0;
            expired_q <= '0;
            status_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i]  <= '1;
                reload_q[i] <= '1;
                mode_q[i]   <= MODE_FREE;
            end
        end else begin
            p_q       <= p_d;
            halted_q  <= halted_d;
            expired_q <= expired_d;
            status_q  <= status_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            mode_q    <= mode_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_count
        assign count[g*WIDTH +: WIDTH] = count_q[g];
    end

    assign expired    = expired_q;
    assign irq_status = status_q;
    assign irq        = |(status_q & irq_en);

endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank: directed stimulus pushes expected expiry events into a
// scoreboard queue; a monitor pops and compares whenever an expired pulse appears.
module tb_timer_bank;

    localparam int W  = 16;
    localparam int CH = 4;
    localparam int PW = 8;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic [1:0]    wr_ch;
    logic [1:0]    wr_mode;
    logic [W-1:0]  wr_load;
    logic [CH-1:0] start;
    logic [PW-1:0] prescale;
    logic [CH-1:0] irq_en;
    logic [CH-1:0] irq_clear;
    logic [CH*W-1:0] count;
    logic [CH-1:0] expired;
    logic [CH-1:0] irq_status;
    logic          irq;

    // Three-channel instance for the out-of-range channel select.
    logic          wr3_en;
    logic [1:0]    wr3_ch;
    logic [2:0]    start3;
    logic [2:0]    irq_en3;
    logic [2:0]    irq_clear3;
    logic [3*W-1:0] count3;
    logic [2:0]    expired3;
    logic [2:0]    irq_status3;
    logic          irq3;

    timer_bank #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_WIDTH(PW)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
        .wr_load(wr_load), .start(start), .prescale(prescale), .irq_en(irq_en),
        .irq_clear(irq_clear), .count(count), .expired(expired),
        .irq_status(irq_status), .irq(irq)
    );

    timer_bank #(.WIDTH(W), .CHANNELS(3), .PRESCALE_WIDTH(PW)) dut3 (
        .clk(clk), .reset(reset), .wr_en(wr3_en), .wr_ch(wr3_ch), .wr_mode(wr_mode),
        .wr_load(wr_load), .start(start3), .prescale(prescale), .irq_en(irq_en3),
        .irq_clear(irq_clear3), .count(count3), .expired(expired3),
        .irq_status(irq_status3), .irq(irq3)
    );

    typedef struct {
        int cyc;
        int ch;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    int  base;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input int ch);
        ev_t e;
        e.cyc = c;
        e.ch  = ch;
        exp_q.push_back(e);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int ch, input logic [1:0] mode, input logic [W-1:0] load);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_mode = mode;
        wr_load = load;
    endtask

    // Monitor: every expiry pulse must match the next scoreboard entry.
    always @(negedge clk) begin : monitor
        ev_t e;
        for (int ch = 0; ch < CH; ch++) begin
            if (expired[ch]) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event: ch %0d pulsed at cyc %0d, none expected", ch, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_cycle", 64'(cyc), 64'(e.cyc));
                    check("ev_channel", 64'(ch), 64'(e.ch));
                    check("ev_status_set", 64'(irq_status[ch]), 64'd1);
                end
            end
        end
        if (expired3 != 3'b000) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event3: got %0h, expected 0", expired3);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_mode = '0; wr_load = '0;
        start = '0; prescale = '0; irq_en = '0; irq_clear = '0;
        wr3_en = 1'b0; wr3_ch = '0; start3 = '0; irq_en3 = '0; irq_clear3 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 64'(count), 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_status", 64'(irq_status), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        check("rst_expired", 64'(expired), 64'd0);
        reset = 1'b0;

        // Out-of-range channel select on a 3-channel bank is ignored.
        wr3_en = 1'b1; wr3_ch = 2'd3; wr_mode = 2'b01; wr_load = 16'h1234;
        next();
        check("wrch_oob_ignored", 64'(count3), 64'hFFFF_FFFF_FFFF);
        wr3_ch = 2'd2; wr_load = 16'h00AA;
        next();
        check("wrch_valid", 64'(count3), 64'h00AA_FFFF_FFFF);
        wr3_en = 1'b0;

        // Cyclic ch1, load 3, prescale 0.
        base = cyc;
        cfg(1, 2'b01, 16'd3);
        start = 4'b0010; irq_en = 4'b0010;
        push(base + 5, 1); push(base + 9, 1); push(base + 13, 1);
        next();
        wr_en = 1'b0;
        check("cyc_load", 64'(count[31:16]), 64'd3);
        check("cyc_irq_low", 64'(irq), 64'd0);
        next(); check("cyc_c2", 64'(count[31:16]), 64'd2);
        next(); check("cyc_c1", 64'(count[31:16]), 64'd1);
        next(); check("cyc_c0", 64'(count[31:16]), 64'd0);
        next();
        check("cyc_reload", 64'(count[31:16]), 64'd3);
        check("cyc_irq_rise", 64'(irq), 64'd1);
        irq_clear = 4'b0010;
        next();
        irq_clear = 4'b0000;
        check("cyc_irq_cleared", 64'(irq), 64'd0);
        next(); next();
        irq_clear = 4'b0010;
        next();
        irq_clear = 4'b0000;
        check("set_beats_clear", 64'(irq_status[1]), 64'd1);
        check("set_beats_clear_irq", 64'(irq), 64'd1);
        repeat (4) next();
        start = 4'b0000;
        check("cyc_second_reload", 64'(count[31:16]), 64'd3);
        irq_clear = 4'b0010;
        next();
        irq_clear = 4'b0000;
        check("clear_status", 64'(irq_status), 64'd0);

        // Free-running wrap on ch0.
        base = cyc;
        cfg(0, 2'b00, 16'd1);
        start = 4'b0001;
        push(base + 3, 0);
        next();
        wr_en = 1'b0;
        check("free_load", 64'(count[15:0]), 64'd1);
        next(); check("free_zero", 64'(count[15:0]), 64'd0);
        next(); check("free_wrap", 64'(count[15:0]), 64'hFFFF);
        next(); check("free_after_wrap", 64'(count[15:0]), 64'hFFFE);
        start = 4'b0000;

        // Write/tick collision on ch3 with reload 0.
        base = cyc;
        cfg(3, 2'b01, 16'd0);
        next();
        check("coll_load0", 64'(count[63:48]), 64'd0);
        start = 4'b1000;
        push(base + 3, 3); push(base + 4, 3);
        next();
        wr_en = 1'b0;
        check("coll_write_wins", 64'(count[63:48]), 64'd0);
        next(); next();
        cfg(3, 2'b01, 16'd7);
        next();
        wr_en = 1'b0; start = 4'b0000;
        check("coll_write_wins_nz", 64'(count[63:48]), 64'd7);

        // Simultaneous events on ch0 and ch3.
        base = cyc;
        cfg(0, 2'b01, 16'd0);
        irq_clear = 4'b1111;
        next();
        irq_clear = 4'b0000;
        check("sim_cleared", 64'(irq_status), 64'd0);
        cfg(3, 2'b01, 16'd0);
        next();
        wr_en = 1'b0; start = 4'b1001; irq_en = 4'b1111;
        push(base + 3, 0); push(base + 3, 3);
        next();
        start = 4'b0000;
        check("sim_status", 64'(irq_status), 64'b1001);
        check("sim_irq", 64'(irq), 64'd1);

        // Asynchronous reset mid-count.
        start = 4'b0100;
        next(); next();
        check("pre_rst_count", 64'(count[47:32]), 64'hFFFD);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_count", 64'(count), 64'hFFFF_FFFF_FFFF_FFFF);
        check("async_rst_status", 64'(irq_status), 64'd0);
        check("async_rst_irq", 64'(irq), 64'd0);
        next();

        // Single-shot ch2, load 2, prescale 3; ticks land on base+4, +8, ...
        base = cyc;
        reset = 1'b0; prescale = 8'd3;
        cfg(2, 2'b10, 16'd2);
        push(base + 12, 2); push(base + 28, 2);
        next();
        wr_en = 1'b0;
        check("ss_load", 64'(count[47:32]), 64'd2);
        repeat (3) next(); check("ss_first_tick", 64'(count[47:32]), 64'd1);
        repeat (3) next(); check("ss_hold_between", 64'(count[47:32]), 64'd1);
        next();            check("ss_zero", 64'(count[47:32]), 64'd0);
        repeat (4) next();
        check("ss_expire_hold", 64'(count[47:32]), 64'd0);
        check("ss_status", 64'(irq_status[2]), 64'd1);
        repeat (8) next();
        check("ss_halted", 64'(count[47:32]), 64'd0);
        cfg(2, 2'b10, 16'd1);
        next();
        wr_en = 1'b0;
        check("ss_rearm", 64'(count[47:32]), 64'd1);
        repeat (7) next(); check("ss_rearm_zero", 64'(count[47:32]), 64'd0);
        repeat (4) next(); check("ss_rearm_hold", 64'(count[47:32]), 64'd0);
        start = 4'b0000;

        // Prescale lowered from 200 to 5 while p = 100.
        reset = 1'b1;
        next();
        base = cyc;
        reset = 1'b0; prescale = 8'd200;
        cfg(1, 2'b01, 16'd0);
        start = 4'b0010;
        push(base + 101, 1); push(base + 107, 1); push(base + 113, 1);
        next();
        wr_en = 1'b0;
        repeat (99) next();
        prescale = 8'd5;
        repeat (13) next();
        start = 4'b0000;
        repeat (3) next();

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
